p_addsub_arb: RTL and testbench
===============================

P_ADDSUB_ARB -- requirements
Module: p_addsub_arb

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset: ports clock (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-002 The block SHALL provide, for each requester n in {0,1}, a request channel:
- req<n>_valid  input  1  request present
- req<n>_ready  output 1  request accepted this cycle
- req<n>_lhs    input  32 left operand
- req<n>_rhs    input  32 right operand
- req<n>_pw     input  5  pack width, one-hot: bit0=32, bit1=16, bit2=8, bit3=4, bit4=2
- req<n>_sub    input  1  subtract if set, else add
REQ-003 The block SHALL provide, for each requester n, a response channel:
- rsp<n>_valid  output 1  response present
- rsp<n>_ready  input  1  response consumed
- rsp<n>_result output 32 packed result
- rsp<n>_cout   output 32 carry-out vector
- rsp<n>_err    output 1  request pw was not one-hot

Function
REQ-004 The block SHALL share one packed add/sub datapath between the two requesters, with a single-entry output register (slot) tagged with its owner.
REQ-005 A request SHALL transfer on a rising edge where req<n>_valid and req<n>_ready are both 1; its response SHALL appear on rsp<n>_valid in the following cycle (latency 1).
REQ-006 Arbitration SHALL be round-robin using a last-grant pointer: if only one requester is valid, it is granted; if both are valid, the requester not granted last is granted.
REQ-007 The pointer SHALL update only on an accepted transfer and SHALL be set to the accepted requester.
REQ-008 req<n>_ready SHALL be 1 only when requester n holds the grant and the slot is empty, or the slot is being drained this cycle (rsp<owner>_valid and rsp<owner>_ready).
REQ-009 At most one req<n>_ready SHALL be 1 in any cycle; req<n>_ready SHALL NOT depend on req<n>_valid of the same requester beyond arbitration.
REQ-010 Drain and accept in the same cycle SHALL be supported, giving one operation per cycle at full throughput.
REQ-011 rsp<n>_valid SHALL be 1 only when the slot is full and owned by n; rsp<n>_result, rsp<n>_cout and rsp<n>_err SHALL stay stable until the response is consumed.
REQ-012 The non-owner response outputs SHALL drive 0.
REQ-013 Slot contents SHALL be the datapath result and carry-out for the accepted operands with c_en=1; each lane wraps modulo 2^lane_width with no inter-lane carry.
REQ-014 If the accepted pw does not have exactly one bit set, the slot SHALL hold result=0, cout=0, err=1; the transfer still completes normally.
REQ-015 A consumer stalling (rsp<owner>_ready=0) SHALL block both requesters, because the single slot is shared.

Reset
REQ-016 On reset: slot empty, all rsp<n>_valid=0, all rsp outputs=0, all req<n>_ready=0 in the reset cycle, and pointer=1 so requester 0 wins the first contention.
REQ-017 Reset asserted mid-operation SHALL discard any slot contents without producing a response.

Structure
REQ-018 A shared package SHALL hold the pw one-hot bit positions, the 32-bit data width constant and the requester-count constant (2).
REQ-019 The block SHALL instantiate exactly one p_addsub sub-module, with c_en tied to 1 and inputs selected by the grant mux.
REQ-020 The one-hot validity check SHALL be a local function or small combinational term; no further sub-modules.

Verification
REQ-021 Single 32-bit add: req0 lhs=0x000000FF, rhs=0x00000001, pw=5'b00001, sub=0 -> next cycle rsp0_valid=1, result=0x00000100, err=0.
REQ-022 8-bit lanes: req1 lhs=0x00FF00FF, rhs=0x00010001, pw=5'b00100, sub=0 -> rsp1 result=0x00000000 (lane wrap, no cross-lane carry).
REQ-023 16-bit subtract: lhs=0x00000000, rhs=0x00010001, pw=5'b00010, sub=1 -> result=0xFFFFFFFF.
REQ-024 Contention after reset: both valid continuously, all rsp_ready=1 -> grants alternate 0,1,0,1, one response per cycle.
REQ-025 Backpressure: rsp0_ready=0 for 3 cycles -> both req_ready=0 and rsp0 outputs unchanged; on release, drain and next accept occur in the same cycle.
REQ-026 Illegal pw 5'b00011 -> err=1, result=0. Reset asserted while slot full -> rsp_valid=0 next cycle and no response delivered.

Source files
------------

// File: rtl/p_addsub_arb_pkg.sv
// Shared constants and types for the two-requester packed add/sub arbiter.
// Pack-width one-hot bit positions, data width and requester count live here.
package p_addsub_arb_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 2;
    localparam int PW_W    = 5;

    localparam int PW_32 = 0;
    localparam int PW_16 = 1;
    localparam int PW_8  = 2;
    localparam int PW_4  = 3;
    localparam int PW_2  = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PW_W-1:0]   pw_t;

    typedef struct packed {
        data_t result;
        data_t cout;
        logic  err;
    } slot_t;

endpackage

// File: rtl/p_addsub.sv
// Packed add/subtract datapath: 32 bits split into equal lanes, no inter-lane carry.
// cout holds each lane's carry-out at the lane's top bit position; sub carries mean no-borrow.
module p_addsub
    import p_addsub_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [PW_W-1:0]   pw,
    input  logic              sub,
    input  logic              c_en,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] cout
);

    int unsigned mask;

    // Lane index mask from pack width; non-one-hot falls back to one full lane.
    always_comb begin
        mask = 32'd31;
        if (pw[PW_32])      mask = 32'd31;
        else if (pw[PW_16]) mask = 32'd15;
        else if (pw[PW_8])  mask = 32'd7;
        else if (pw[PW_4])  mask = 32'd3;
        else if (pw[PW_2])  mask = 32'd1;
    end

    // Ripple carry that restarts with the sub carry-in at every lane boundary.
    always_comb begin
        logic c;
        logic bb;
        logic co;
        result = '0;
        cout   = '0;
        c      = 1'b0;
        bb     = 1'b0;
        co     = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if ((i & mask) == 0) begin
                c = sub & c_en;
            end
            bb        = b[i] ^ sub;
            result[i] = a[i] ^ bb ^ c;
            co        = (a[i] & bb) | (a[i] & c) | (bb & c);
            if ((i & mask) == mask) begin
                cout[i] = co;
            end
            c = co & c_en;
        end
    end

endmodule

// File: rtl/p_addsub_arb.sv
// Two requesters share one packed add/sub datapath and one owner-tagged output slot.
// Round-robin grant on a last-grant pointer; drain and accept may overlap each cycle.
module p_addsub_arb
    import p_addsub_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_lhs,
    input  logic [DATA_W-1:0] req0_rhs,
    input  logic [PW_W-1:0]   req0_pw,
    input  logic              req0_sub,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_lhs,
    input  logic [DATA_W-1:0] req1_rhs,
    input  logic [PW_W-1:0]   req1_pw,
    input  logic              req1_sub,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic [DATA_W-1:0] rsp0_cout,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [DATA_W-1:0] rsp1_cout,
    output logic              rsp1_err
);

    logic               last_grant;
    logic               grant;
    logic               slot_full;
    logic               slot_owner;
    slot_t              slot;
    slot_t              nxt;
    logic               drain;
    logic               can_accept;
    logic               accept;
    logic [NUM_REQ-1:0] rsp_ready_vec;
    data_t              op_lhs;
    data_t              op_rhs;
    pw_t                op_pw;
    logic               op_sub;
    data_t              dp_result;
    data_t              dp_cout;

    function automatic logic is_onehot(input pw_t p);
        return (p != '0) && ((p & (p - 5'd1)) == '0);
    endfunction

    // Round-robin: lone requester wins, contention goes to the one not granted last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};
    assign drain         = slot_full & rsp_ready_vec[slot_owner];
    assign can_accept    = ~reset & (~slot_full | drain);
    assign req0_ready    = can_accept & ~grant;
    assign req1_ready    = can_accept & grant;
    assign accept        = grant ? (req1_ready & req1_valid)
                                 : (req0_ready & req0_valid);

    assign op_lhs = grant ? req1_lhs : req0_lhs;
    assign op_rhs = grant ? req1_rhs : req0_rhs;
    assign op_pw  = grant ? req1_pw  : req0_pw;
    assign op_sub = grant ? req1_sub : req0_sub;

    p_addsub u_addsub (
        .a      (op_lhs),
        .b      (op_rhs),
        .pw     (op_pw),
        .sub    (op_sub),
        .c_en   (1'b1),
        .result (dp_result),
        .cout   (dp_cout)
    );

    // Slot payload: datapath output, or a zeroed error record on a bad pack width.
    always_comb begin
        nxt = '0;
        if (is_onehot(op_pw)) begin
            nxt.result = dp_result;
            nxt.cout   = dp_cout;
        end else begin
            nxt.err = 1'b1;
        end
    end

    // Slot and pointer: accept refills (even while draining), drain alone empties.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_full  <= 1'b0;
            slot_owner <= 1'b0;
            last_grant <= 1'b1;
            slot       <= '0;
        end else if (accept) begin
            slot_full  <= 1'b1;
            slot_owner <= grant;
            last_grant <= grant;
            slot       <= nxt;
        end else if (drain) begin
            slot_full  <= 1'b0;
        end
    end

    assign rsp0_valid  = slot_full & ~slot_owner;
    assign rsp1_valid  = slot_full & slot_owner;
    assign rsp0_result = rsp0_valid ? slot.result : '0;
    assign rsp0_cout   = rsp0_valid ? slot.cout   : '0;
    assign rsp0_err    = rsp0_valid & slot.err;
    assign rsp1_result = rsp1_valid ? slot.result : '0;
    assign rsp1_cout   = rsp1_valid ? slot.cout   : '0;
    assign rsp1_err    = rsp1_valid & slot.err;

endmodule

// File: tb/tb_p_addsub_arb.sv
// Self-checking bench for p_addsub_arb: directed table, corner sequences,
// and randomized traffic against a lane-arithmetic reference model.
module tb_p_addsub_arb;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        v   [2];
    logic        rdy [2];
    logic [31:0] lhs [2];
    logic [31:0] rhs [2];
    logic [4:0]  pw  [2];
    logic        sb  [2];
    logic        rv  [2];
    logic        rr  [2];
    logic [31:0] res [2];
    logic [31:0] co  [2];
    logic        er  [2];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    p_addsub_arb dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (v[0]),
        .req0_ready  (rdy[0]),
        .req0_lhs    (lhs[0]),
        .req0_rhs    (rhs[0]),
        .req0_pw     (pw[0]),
        .req0_sub    (sb[0]),
        .req1_valid  (v[1]),
        .req1_ready  (rdy[1]),
        .req1_lhs    (lhs[1]),
        .req1_rhs    (rhs[1]),
        .req1_pw     (pw[1]),
        .req1_sub    (sb[1]),
        .rsp0_valid  (rv[0]),
        .rsp0_ready  (rr[0]),
        .rsp0_result (res[0]),
        .rsp0_cout   (co[0]),
        .rsp0_err    (er[0]),
        .rsp1_valid  (rv[1]),
        .rsp1_ready  (rr[1]),
        .rsp1_result (res[1]),
        .rsp1_cout   (co[1]),
        .rsp1_err    (er[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each lane is plain modular arithmetic on its unsigned value.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] p, input logic s,
                                  output logic [31:0] r, output logic [31:0] c,
                                  output logic e);
        int w;
        r = '0;
        c = '0;
        e = 1'b0;
        case (p)
            5'b00001: w = 32;
            5'b00010: w = 16;
            5'b00100: w = 8;
            5'b01000: w = 4;
            5'b10000: w = 2;
            default: begin
                e = 1'b1;
                return;
            end
        endcase
        for (int k = 0; k < 32 / w; k++) begin
            longint unsigned m, x, y, t;
            bit carry;
            m = 64'd1 << w;
            x = 64'(a >> (k * w)) % m;
            y = 64'(b >> (k * w)) % m;
            if (s) begin
                t = x + m - y;
                carry = (x >= y);
            end else begin
                t = x + y;
                carry = (t >= m);
            end
            r = r | (32'(t % m) << (k * w));
            if (carry) c[k * w + w - 1] = 1'b1;
        end
    endfunction

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  p;
        logic        s;
        logic [31:0] r;
        logic [31:0] c;
        logic        e;
    } vec_t;

    vec_t vt [8];

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Model state for the random phase.
    logic        m_full;
    logic        m_owner;
    logic        m_last;
    logic [31:0] m_r;
    logic [31:0] m_c;
    logic        m_e;

    initial begin
        int n;
        int o;
        logic g;
        logic er_x [2];
        logic [31:0] hold;

        vt[0] = '{0, 32'h000000FF, 32'h00000001, 5'b00001, 1'b0,
                  32'h00000100, 32'h00000000, 1'b0};
        vt[1] = '{1, 32'h00FF00FF, 32'h00010001, 5'b00100, 1'b0,
                  32'h00000000, 32'h00800080, 1'b0};
        vt[2] = '{0, 32'h00000000, 32'h00010001, 5'b00010, 1'b1,
                  32'hFFFFFFFF, 32'h00000000, 1'b0};
        vt[3] = '{1, 32'h12345678, 32'h87654321, 5'b00011, 1'b0,
                  32'h00000000, 32'h00000000, 1'b1};
        vt[4] = '{0, 32'hDEADBEEF, 32'h00000001, 5'b00000, 1'b1,
                  32'h00000000, 32'h00000000, 1'b1};
        vt[5] = '{1, 32'h12345678, 32'h11111111, 5'b01000, 1'b0,
                  32'h23456789, 32'h00000000, 1'b0};
        vt[6] = '{0, 32'hFFFFFFFF, 32'h55555555, 5'b10000, 1'b1,
                  32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0};
        vt[7] = '{1, 32'h00000005, 32'h00000003, 5'b00001, 1'b1,
                  32'h00000002, 32'h80000000, 1'b0};

        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b1;
            lhs[i] = 32'h1;
            rhs[i] = 32'h2;
            pw[i] = 5'b00001;
            sb[i] = 1'b0;
            rr[i] = 1'b1;
        end

        // Reset state, with both requesters asserting valid.
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("reset_ready0", rdy[0], 1'b0);
        chk("reset_ready1", rdy[1], 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_rsp%0d_valid", i), rv[i], 1'b0);
            chk($sformatf("reset_rsp%0d_result", i), res[i], 32'h0);
            chk($sformatf("reset_rsp%0d_cout", i), co[i], 32'h0);
            chk($sformatf("reset_rsp%0d_err", i), er[i], 1'b0);
        end
        v[0] = 1'b0;
        v[1] = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Directed table: one transfer, response next cycle, then drained.
        for (int i = 0; i < 8; i++) begin
            n = vt[i].port;
            o = 1 - n;
            v[n] = 1'b1;
            lhs[n] = vt[i].a;
            rhs[n] = vt[i].b;
            pw[n] = vt[i].p;
            sb[n] = vt[i].s;
            @(negedge clock);
            chk($sformatf("vec%0d_ready", i), rdy[n], 1'b1);
            chk($sformatf("vec%0d_other_ready", i), rdy[o], 1'b0);
            @(posedge clock);
            #1;
            v[n] = 1'b0;
            @(negedge clock);
            chk($sformatf("vec%0d_valid", i), rv[n], 1'b1);
            chk($sformatf("vec%0d_result", i), res[n], vt[i].r);
            chk($sformatf("vec%0d_cout", i), co[n], vt[i].c);
            chk($sformatf("vec%0d_err", i), er[n], vt[i].e);
            chk($sformatf("vec%0d_other_valid", i), rv[o], 1'b0);
            chk($sformatf("vec%0d_other_result", i), res[o], 32'h0);
            @(posedge clock);
            #1;
        end

        // Contention after reset: grants alternate starting with requester 0.
        do_reset();
        v[0] = 1'b1;
        v[1] = 1'b1;
        rr[0] = 1'b1;
        rr[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk($sformatf("rr_c%0d_ready0", k), rdy[0], (k % 2) == 0);
            chk($sformatf("rr_c%0d_ready1", k), rdy[1], (k % 2) == 1);
            if (k > 0) begin
                chk($sformatf("rr_c%0d_rsp_owner", k), rv[(k - 1) % 2], 1'b1);
                chk($sformatf("rr_c%0d_rsp_other", k), rv[k % 2], 1'b0);
            end
            @(posedge clock);
            #1;
        end

        // Backpressure: stalled rsp0 blocks both requesters, then overlap.
        v[0] = 1'b0;
        v[1] = 1'b0;
        do_reset();
        lhs[0] = 32'd5;
        rhs[0] = 32'd7;
        pw[0] = 5'b00001;
        sb[0] = 1'b0;
        lhs[1] = 32'd3;
        rhs[1] = 32'd4;
        pw[1] = 5'b00001;
        sb[1] = 1'b0;
        v[0] = 1'b1;
        v[1] = 1'b1;
        rr[0] = 1'b0;
        @(negedge clock);
        chk("bp_first_ready0", rdy[0], 1'b1);
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("bp_c%0d_ready0", k), rdy[0], 1'b0);
            chk($sformatf("bp_c%0d_ready1", k), rdy[1], 1'b0);
            chk($sformatf("bp_c%0d_valid", k), rv[0], 1'b1);
            chk($sformatf("bp_c%0d_result", k), res[0], 32'd12);
            @(posedge clock);
            #1;
        end
        rr[0] = 1'b1;
        @(negedge clock);
        chk("bp_release_ready1", rdy[1], 1'b1);
        chk("bp_release_ready0", rdy[0], 1'b0);
        @(posedge clock);
        #1;
        v[0] = 1'b0;
        v[1] = 1'b0;
        @(negedge clock);
        chk("bp_next_rsp1_valid", rv[1], 1'b1);
        chk("bp_next_rsp1_result", res[1], 32'd7);
        chk("bp_next_rsp0_valid", rv[0], 1'b0);
        @(posedge clock);
        #1;

        // Reset while the slot is full discards the response.
        rr[0] = 1'b0;
        v[0] = 1'b1;
        @(posedge clock);
        #1;
        v[0] = 1'b0;
        @(negedge clock);
        chk("rst_mid_loaded", rv[0], 1'b1);
        reset = 1'b1;
        v[1] = 1'b1;
        #1;
        chk("rst_mid_ready1", rdy[1], 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        v[1] = 1'b0;
        rr[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk($sformatf("rst_mid_c%0d_valid0", k), rv[0], 1'b0);
            chk($sformatf("rst_mid_c%0d_result0", k), res[0], 32'h0);
            @(posedge clock);
            #1;
        end

        // Randomized traffic against the model.
        do_reset();
        m_full = 1'b0;
        m_owner = 1'b0;
        m_last = 1'b1;
        m_r = '0;
        m_c = '0;
        m_e = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic er0;
            logic er1;
            logic free;
            logic [31:0] xr;
            logic [31:0] xc;
            logic xe;
            for (int i = 0; i < 2; i++) begin
                v[i] = ($urandom_range(0, 9) < 7);
                rr[i] = ($urandom_range(0, 9) < 7);
                lhs[i] = $urandom;
                rhs[i] = $urandom;
                sb[i] = $urandom_range(0, 1);
                if ($urandom_range(0, 5) == 5) pw[i] = 5'($urandom);
                else pw[i] = 5'b00001 << $urandom_range(0, 4);
            end
            @(negedge clock);
            if (v[0] && v[1]) g = ~m_last;
            else g = v[1];
            free = !m_full || rr[m_owner];
            er0 = free && !g;
            er1 = free && g;
            chk($sformatf("rnd%0d_ready0", cyc), rdy[0], er0);
            chk($sformatf("rnd%0d_ready1", cyc), rdy[1], er1);
            for (int i = 0; i < 2; i++) begin
                logic own;
                own = m_full && (m_owner == i[0]);
                chk($sformatf("rnd%0d_rsp%0d_valid", cyc, i), rv[i], own);
                chk($sformatf("rnd%0d_rsp%0d_result", cyc, i), res[i],
                    own ? m_r : 32'h0);
                chk($sformatf("rnd%0d_rsp%0d_cout", cyc, i), co[i],
                    own ? m_c : 32'h0);
                chk($sformatf("rnd%0d_rsp%0d_err", cyc, i), er[i],
                    own ? m_e : 1'b0);
            end
            if (free && v[g]) begin
                model(lhs[g], rhs[g], pw[g], sb[g], xr, xc, xe);
                m_r = xr;
                m_c = xc;
                m_e = xe;
                m_full = 1'b1;
                m_owner = g;
                m_last = g;
            end else if (m_full && rr[m_owner]) begin
                m_full = 1'b0;
            end
            @(posedge clock);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
